edac_access_arbiter: RTL and testbench

- Sequences and shares the dual-nibble EDAC datapath (registered-output EDAC, one-cycle latency, 32-bit encoded word per byte written) between two requesters: port 0 (instruction fetch) and port 1 (data memory).
- Grants one access at a time using a round-robin policy, drives the EDAC enable, mode and data inputs, and captures the registered result.
- Detects the EDAC uncorrectable-error code and reports it to the requester, and counts it in a saturating counter.

---
 rtl/edac_access_arbiter.sv | 153 +++++++++++++++
 tb/tb_edac_access_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edac_access_arbiter.sv
// edac_access_arbiter: shares one registered-output EDAC (one-cycle latency)
// between an instruction-fetch port (0) and a data-memory port (1).
// Round-robin grant, four-state sequencer IDLE -> ISSUE -> CAPTURE -> DONE,
// uncorrectable-error detection and a saturating error counter.
// Optional feature macro: EDAC_RETRY_EN (re-issue errored reads up to
// MAX_RETRY times before reporting them).
module edac_access_arbiter #(
  parameter logic [31:0] ERROR_CODE = 32'hFFFF_FFFF,
  parameter int          CNT_W      = 8
`ifdef EDAC_RETRY_EN
  ,
  parameter int          MAX_RETRY  = 2
`endif
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             read0,
  input  logic             read1,
  input  logic [31:0]      din0,
  input  logic [31:0]      din1,
  output logic             ack0,
  output logic             ack1,
  output logic [31:0]      rdata,
  output logic             err,
  output logic             edac_en,
  output logic             edac_read,
  output logic [31:0]      edac_din,
  input  logic [31:0]      edac_dout,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t             state_reg, state_next;
  logic               win_reg, win_next;
  logic               rd_reg;
  logic [31:0]        din_reg;
  logic               rr_reg;
  logic [1:0]         ack_reg;
  logic [1:0]         port_done;
  logic [31:0]        rdata_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   err_cnt_reg;
  logic               busy_reg;
  logic               dout_err;
  logic               finish_access;

  // A read that came back as the uncorrectable code; writes never qualify
  // because an encoded byte is zero-padded in its upper half.
  assign dout_err = rd_reg && (edac_dout == ERROR_CODE);

  // The current attempt is the last one for this access when CAPTURE hands off to DONE.
  assign finish_access = (state_reg == CAPTURE) && (state_next == DONE);

`ifdef EDAC_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RETRY_W-1:0] retry_cnt_reg;
  logic               retry_go;

  assign retry_go = dout_err && (retry_cnt_reg < RETRY_W'(MAX_RETRY));

  // Attempt counter: cleared while idle, bumped on every re-issue.
  always_ff @(posedge CLK) begin
    if (reset || state_reg == IDLE) retry_cnt_reg <= '0;
    else if (state_reg == CAPTURE && retry_go) retry_cnt_reg <= retry_cnt_reg + RETRY_W'(1);
  end
`endif

  // Next-state and grant decision; a lone request wins outright, a tie goes to rr_reg.
  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          state_next = ISSUE;
          win_next   = (req0 && req1) ? rr_reg : req1;
        end
      end
      ISSUE:   state_next = CAPTURE;
`ifdef EDAC_RETRY_EN
      CAPTURE: state_next = retry_go ? ISSUE : DONE;
`else
      CAPTURE: state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus the operation latched at grant time.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= IDLE;
      win_reg   <= 1'b0;
      rd_reg    <= 1'b0;
      din_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == ISSUE) begin
        win_reg <= win_next;
        rd_reg  <= win_next ? read1 : read0;
        din_reg <= win_next ? din1 : din0;
      end
    end
  end

  // Per-port completion: the winner gets its ack pulse in the DONE cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign port_done[gi] = finish_access && (win_reg == 1'(gi));
    end
  endgenerate

  // Registered result, ack, fairness pointer, error count and busy flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ack_reg     <= 2'b00;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      rr_reg      <= 1'b0;
      err_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      ack_reg  <= port_done;
      err_reg  <= finish_access && dout_err;
      busy_reg <= (state_next != IDLE);
      if (state_reg == CAPTURE) rdata_reg <= edac_dout;
      if (state_reg == DONE) begin
        rr_reg <= ~win_reg;
        if (err_reg && err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
      end
    end
  end

  // EDAC drive is decoded straight from the state so it lines up with ISSUE.
  assign edac_en   = (state_reg == ISSUE);
  assign edac_read = edac_en && rd_reg;
  assign edac_din  = edac_en ? din_reg : '0;

  assign ack0    = ack_reg[0];
  assign ack1    = ack_reg[1];
  assign rdata   = rdata_reg;
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_edac_access_arbiter.sv
// Bench for edac_access_arbiter: a stub EDAC drives edac_dout, per-port
// drivers push expected results into scoreboard queues, and a monitor on the
// falling edge pops and compares on every ack.
module tb_edac_access_arbiter;

  localparam logic [31:0] ERROR_CODE = 32'hFFFF_FFFF;
`ifdef EDAC_RETRY_EN
  localparam int MR = 2;
`else
  localparam int MR = 0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, read0 = 1'b0, read1 = 1'b0;
  logic [31:0] din0 = '0, din1 = '0;
  logic        ack0, ack1, err, edac_en, edac_read, busy;
  logic [31:0] rdata, edac_din;
  logic [31:0] edac_dout = '0;
  logic [7:0]  err_cnt;

  always #5 CLK = ~CLK;

  edac_access_arbiter dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .req1(req1), .read0(read0), .read1(read1),
    .din0(din0), .din1(din1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .edac_en(edac_en), .edac_read(edac_read), .edac_din(edac_din),
    .edac_dout(edac_dout), .err_cnt(err_cnt), .busy(busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          attempts;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0, n_mis = 0;
  int   model_cnt = 0, model_next = 0;
  bit   both_phase = 1'b0;
  int   en_cnt = 0, busy_cnt = 0;
  logic prev_en = 1'b0;
  int   edac_att = 0;
  int   mp;
  exp_t me;

  function automatic logic [7:0] nib_code(logic [3:0] n);
    return {n, n[3] ^ n[2] ^ n[1], n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0], ^n};
  endfunction

  function automatic logic [31:0] enc(logic [7:0] b);
    return {16'h0000, nib_code(b[7:4]), nib_code(b[3:0])};
  endfunction

  function automatic logic [31:0] dec(logic [31:0] w);
    return {24'h0, w[15:12], w[7:4]};
  endfunction

  // Stub EDAC: bit 31 of a read word = persistent fault, bit 30 = fault on
  // the first attempt of an access only.
  always @(posedge CLK) begin
    if (reset) begin
      edac_dout <= '0;
      edac_att  <= 0;
    end else if (edac_en) begin
      edac_att <= edac_att + 1;
      if (!edac_read) edac_dout <= enc(edac_din[7:0]);
      else if (edac_din[31] || (edac_din[30] && edac_att == 0)) edac_dout <= ERROR_CODE;
      else edac_dout <= dec(edac_din);
    end else if (ack0 || ack1) begin
      edac_att <= 0;
    end
  end

  // Reference: what one access should return, from the operation alone.
  function automatic exp_t expect_of(logic rd, logic [31:0] d);
    exp_t e;
    if (!rd) begin
      e.rdata = enc(d[7:0]); e.err = 1'b0; e.attempts = 1;
    end else if (d[31]) begin
      e.rdata = ERROR_CODE; e.err = 1'b1; e.attempts = 1 + MR;
    end else if (d[30] && MR == 0) begin
      e.rdata = ERROR_CODE; e.err = 1'b1; e.attempts = 1;
    end else if (d[30]) begin
      e.rdata = dec(d); e.err = 1'b0; e.attempts = 2;
    end else begin
      e.rdata = dec(d); e.err = 1'b0; e.attempts = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    w[31] = ($urandom_range(0, 7) == 0);
    w[30] = ($urandom_range(0, 7) == 0);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One access on port p; returns the number of falling edges until its ack.
  task automatic issue(input int p, input logic rd, input logic [31:0] d,
                       input bit keep, output int lat);
    exp_t e;
    e = expect_of(rd, d);
    if (p == 0) begin
      req0 = 1'b1; read0 = rd; din0 = d; q0.push_back(e);
    end else begin
      req1 = 1'b1; read1 = rd; din1 = d; q1.push_back(e);
    end
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge CLK);
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++; n_mis++;
      $display("FAIL ack_timeout: port %0d got no ack within 80 cycles", p);
    end
    if (!keep) begin
      if (p == 0) req0 = 1'b0;
      else req1 = 1'b0;
    end
  endtask

  // Monitor: per-cycle EDAC-enable spacing, and a full scoreboard check per ack.
  always @(negedge CLK) begin
    if (reset) begin
      en_cnt = 0; busy_cnt = 0; prev_en = 1'b0;
      model_cnt = 0; model_next = 0;
      q0.delete(); q1.delete();
    end else begin
      if (edac_en) begin
        en_cnt++;
        chk("edac_en_consecutive", 32'(prev_en), 32'd0);
      end
      if (busy) busy_cnt++;
      if (ack0 || ack1) begin
        mp = ack1 ? 1 : 0;
        chk("ack_overlap", 32'(ack0 & ack1), 32'd0);
        if ((mp == 0 && q0.size() == 0) || (mp == 1 && q1.size() == 0)) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_ack: port %0d acked with nothing outstanding", mp);
        end else begin
          me = (mp == 0) ? q0.pop_front() : q1.pop_front();
          chk("rdata", rdata, me.rdata);
          chk("err", 32'(err), 32'(me.err));
          chk("edac_en_pulses", 32'(en_cnt), 32'(me.attempts));
          chk("busy_cycles", 32'(busy_cnt), 32'(3 + 2 * (me.attempts - 1)));
          chk("err_cnt_before", 32'(err_cnt), 32'(model_cnt));
          if (both_phase) chk("rr_order", 32'(mp), 32'(model_next));
          $display("ack port %0d rdata %h err %0d pulses %0d err_cnt %0d",
                   mp, rdata, err, en_cnt, err_cnt);
          model_next = 1 - mp;
          if (me.err && model_cnt < 255) model_cnt++;
        end
        en_cnt = 0;
        busy_cnt = 0;
      end
      prev_en = edac_en;
    end
  end

  initial begin
    int lat;
    bit seen;
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_edac_en", 32'(edac_en), 32'd0);
    chk("rst_edac_read", 32'(edac_read), 32'd0);
    chk("rst_edac_din", edac_din, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    // Single write from idle on port 0.
    issue(0, 1'b0, 32'h0000_00A5, 1'b0, lat);
    chk("write_latency", 32'(lat), 32'd3);
    @(negedge CLK);
    chk("err_cnt_after_write", 32'(err_cnt), 32'd0);

    // Persistent read fault on port 1.
    issue(1, 1'b1, 32'h8000_1234, 1'b0, lat);
    chk("err_read_latency", 32'(lat), 32'(3 + 2 * MR));
    @(negedge CLK);
    chk("err_cnt_after_err_read", 32'(err_cnt), 32'd1);

    // Fault on the first attempt only; decodes to 8'h3C once it reads clean.
    issue(0, 1'b1, 32'h4000_30C0, 1'b0, lat);
    chk("transient_latency", 32'(lat), (MR > 0) ? 32'd5 : 32'd3);
    @(negedge CLK);
    chk("err_cnt_after_transient", 32'(err_cnt), (MR > 0) ? 32'd1 : 32'd2);

    // Reset while an access from port 1 is in ISSUE.
    read1 = 1'b1; din1 = 32'h0000_5A00; req1 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (edac_en) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++; n_mis++;
      $display("FAIL issue_wait: edac_en never rose for the aborted access");
    end
    reset = 1'b1;
    req1 = 1'b0;
    @(negedge CLK);
    chk("abort_ack0", 32'(ack0), 32'd0);
    chk("abort_ack1", 32'(ack1), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err_cnt", 32'(err_cnt), 32'd0);
    chk("abort_edac_en", 32'(edac_en), 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    // Both ports held high: grants must alternate starting at port 0.
    both_phase = 1'b1;
    fork
      begin
        int l0;
        for (int i = 0; i < 2; i++) issue(0, 1'($urandom_range(0, 1)), rnd_word(), i < 1, l0);
      end
      begin
        int l1;
        for (int i = 0; i < 2; i++) issue(1, 1'($urandom_range(0, 1)), rnd_word(), i < 1, l1);
      end
    join
    @(negedge CLK);
    both_phase = 1'b0;

    // Random traffic on both ports with random gaps.
    fork
      begin
        int l0, g0;
        for (int i = 0; i < 30; i++) begin
          g0 = $urandom_range(0, 3);
          issue(0, 1'($urandom_range(0, 1)), rnd_word(), (g0 == 0) && (i < 29), l0);
          if (g0 > 1) repeat (g0 - 1) @(negedge CLK);
        end
      end
      begin
        int l1, g1;
        for (int i = 0; i < 30; i++) begin
          g1 = $urandom_range(0, 3);
          issue(1, 1'($urandom_range(0, 1)), rnd_word(), (g1 == 0) && (i < 29), l1);
          if (g1 > 1) repeat (g1 - 1) @(negedge CLK);
        end
      end
    join
    @(negedge CLK);

    // Enough faulty reads to drive the counter into saturation.
    for (int i = 0; i < 300; i++) issue(1, 1'b1, 32'h8000_0000 | 32'($urandom_range(0, 255)), i < 299, lat);
    @(negedge CLK);
    chk("err_cnt_saturated", 32'(err_cnt), 32'h0000_00FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
